// File: rtl/w5300_socket_array_conf.sv
// Brings W5300 sockets 0..NUM_SOCKETS-1 up one after another (TCP listen or UDP open)
// through a single-request bus engine, retrying a socket with close/reopen on status timeout.
module w5300_socket_array_conf #(
  parameter int          NUM_SOCKETS = 2,
  parameter logic [15:0] PORT_BASE   = 16'd7000,
  parameter logic [7:0]  UDP_MASK    = 8'h00,
  parameter int          OP_TIMEOUT  = 50,
  parameter int          MAX_RETRY   = 3,
  parameter logic [7:0]  KPALVTR     = 8'd1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   op_state,
  input  logic [15:0]            rd_data,
  output logic [10:0]            addr,
  output logic [15:0]            wr_data,
  output logic                   done,
  output logic [NUM_SOCKETS-1:0] sock_ok,
  output logic                   busy
);

  localparam int IDX_W   = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W   = $clog2(OP_TIMEOUT + 2);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SOCKETS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]   TMO_LIM   = TMO_W'(OP_TIMEOUT);

  localparam logic [5:0] OFF_MR    = 6'h00;
  localparam logic [5:0] OFF_CR    = 6'h02;
  localparam logic [5:0] OFF_IMR   = 6'h04;
  localparam logic [5:0] OFF_SSR   = 6'h08;
  localparam logic [5:0] OFF_PORTR = 6'h0A;
  localparam logic [5:0] OFF_KPAL  = 6'h2E;

  localparam logic [9:0] IDLE_REG = 10'h3FE;

  typedef enum logic [2:0] {
    IDLE, CFG, WAIT_OPEN, LISTEN, WAIT_LISTEN, CLOSE, NEXT, DONE
  } state_t;

  typedef enum logic [2:0] {
    ST_MR, ST_PORT, ST_IMR, ST_KPAL, ST_OPEN
  } step_t;

  state_t               state, state_next;
  step_t                step, step_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [RETRY_W-1:0]   retry, retry_next;
  logic [TMO_W-1:0]     tmo, tmo_next;
  logic [NUM_SOCKETS-1:0] ok_next;

  logic                   is_udp;
  logic [7:0]             tgt_open;
  logic                   timeout;
  logic [NUM_SOCKETS-1:0] ok_bit;
  logic                   unused_hi;

  function automatic logic [9:0] reg_addr(input logic [IDX_W-1:0] n, input logic [5:0] off);
    return 10'h200 + (10'(n) << 6) + 10'(off);
  endfunction

  assign is_udp    = UDP_MASK[3'(idx)];
  assign tgt_open  = is_udp ? 8'h22 : 8'h13;
  assign timeout   = (tmo == TMO_LIM);
  assign ok_bit    = NUM_SOCKETS'(1) << idx;
  assign unused_hi = ^rd_data[15:8];
  assign done      = (state == DONE);
  assign busy      = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= ST_MR;
      idx     <= '0;
      retry   <= '0;
      tmo     <= '0;
      sock_ok <= '0;
    end else begin
      state   <= state_next;
      step    <= step_next;
      idx     <= idx_next;
      retry   <= retry_next;
      tmo     <= tmo_next;
      sock_ok <= ok_next;
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    idx_next   = idx;
    retry_next = retry;
    ok_next    = sock_ok;
    tmo_next   = tmo;
    addr       = {1'b0, IDLE_REG};
    wr_data    = 16'h0000;

    case (state)
      IDLE: begin
        if (enable) begin
          state_next = CFG;
          step_next  = ST_MR;
          idx_next   = '0;
          retry_next = '0;
          ok_next    = '0;
        end
      end

      CFG: begin
        case (step)
          ST_MR: begin
            addr    = {1'b1, reg_addr(idx, OFF_MR)};
            wr_data = is_udp ? 16'h0002 : 16'h0001;
          end
          ST_PORT: begin
            addr    = {1'b1, reg_addr(idx, OFF_PORTR)};
            wr_data = PORT_BASE + 16'(idx);
          end
          ST_IMR: begin
            addr    = {1'b1, reg_addr(idx, OFF_IMR)};
            wr_data = 16'h001F;
          end
          ST_KPAL: begin
            addr    = {1'b1, reg_addr(idx, OFF_KPAL)};
            wr_data = {KPALVTR, 8'h01};
          end
          default: begin
            addr    = {1'b1, reg_addr(idx, OFF_CR)};
            wr_data = 16'h0001;
          end
        endcase
        // The write stays on the bus until the engine acknowledges it.
        if (op_state) begin
          case (step)
            ST_MR:   step_next = ST_PORT;
            ST_PORT: step_next = ST_IMR;
            ST_IMR:  step_next = is_udp ? ST_OPEN : ST_KPAL;
            ST_KPAL: step_next = ST_OPEN;
            default: begin
              step_next  = ST_MR;
              state_next = WAIT_OPEN;
            end
          endcase
        end
      end

      WAIT_OPEN: begin
        addr = {1'b0, reg_addr(idx, OFF_SSR)};
        if (op_state && rd_data[7:0] == tgt_open) begin
          if (is_udp) begin
            ok_next    = sock_ok | ok_bit;
            state_next = NEXT;
          end else begin
            state_next = LISTEN;
          end
        end else if (timeout) begin
          state_next = (retry < RETRY_LIM) ? CLOSE : NEXT;
        end
      end

      LISTEN: begin
        addr    = {1'b1, reg_addr(idx, OFF_CR)};
        wr_data = 16'h0002;
        if (op_state) state_next = WAIT_LISTEN;
      end

      WAIT_LISTEN: begin
        addr = {1'b0, reg_addr(idx, OFF_SSR)};
        if (op_state && rd_data[7:0] == 8'h14) begin
          ok_next    = sock_ok | ok_bit;
          state_next = NEXT;
        end else if (timeout) begin
          state_next = (retry < RETRY_LIM) ? CLOSE : NEXT;
        end
      end

      CLOSE: begin
        addr    = {1'b1, reg_addr(idx, OFF_CR)};
        wr_data = 16'h0010;
        if (op_state) begin
          retry_next = retry + 1'b1;
          step_next  = ST_MR;
          state_next = CFG;
        end
      end

      NEXT: begin
        retry_next = '0;
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + 1'b1;
          step_next  = ST_MR;
          state_next = CFG;
        end
      end

      DONE: begin
        if (!enable) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Counter restarts on every state change, so each wait state begins its window at zero.
    if (state_next != state) begin
      tmo_next = '0;
    end else if ((state == WAIT_OPEN || state == WAIT_LISTEN) && tmo != TMO_LIM) begin
      tmo_next = tmo + 1'b1;
    end
  end

endmodule

// File: doc/w5300_socket_array_conf.md
W5300_SOCKET_ARRAY_CONF -- requirements
Module: w5300_socket_array_conf

Interface
REQ-001 SHALL have parameter NUM_SOCKETS, default 2, number of consecutive sockets 0..NUM_SOCKETS-1 to configure; legal range 1..8.
REQ-002 SHALL have parameter PORT_BASE, default 7000, so that socket n listens on port PORT_BASE+n, 16-bit.
REQ-003 SHALL have parameter UDP_MASK, default 0, where bit n=1 opens socket n as UDP and bit n=0 opens it as TCP server.
REQ-004 SHALL have parameter OP_TIMEOUT, default 50, the status-poll timeout in clk cycles.
REQ-005 SHALL have parameter MAX_RETRY, default 3, the number of close/reopen retries per socket before that socket is marked failed.
REQ-006 SHALL have parameter KPALVTR, default 1, the TCP keep-alive value written to the upper byte of KPALVTR_PROTOR.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port enable, input, 1 bit: level start request.
REQ-010 SHALL have port op_state, input, 1 bit: one-cycle pulse meaning the current bus operation completed; rd_data is valid in that cycle.
REQ-011 SHALL have port rd_data, input, 16 bits: read data from the bus engine.
REQ-012 SHALL have port addr, output, 11 bits: bit 10 is direction (1 = write, 0 = read) and bits 9:0 are the register address.
REQ-013 SHALL have port wr_data, output, 16 bits: write data.
REQ-014 SHALL have port done, output, 1 bit: all sockets have been processed.
REQ-015 SHALL have port sock_ok, output, NUM_SOCKETS bits: bit n=1 means socket n reached its target state.
REQ-016 SHALL have port busy, output, 1 bit: a sequence is in progress.

Function
REQ-017 SHALL compute socket n register addresses as base 0x200+0x40*n, with offsets MR +0x00, CR +0x02, IMR +0x04, SSR +0x08, PORTR +0x0A, KPALVTR_PROTOR +0x2E.
REQ-018 SHALL output the idle bus word {addr=read 0x3FE, wr_data=0} in every state that issues no operation.
REQ-019 SHALL implement the states IDLE, CFG, WAIT_OPEN, LISTEN, WAIT_LISTEN, CLOSE, NEXT, DONE.
REQ-020 IDLE: SHALL go to CFG with socket index 0 when enable=1; busy SHALL be 1 in every state except IDLE and DONE.
REQ-021 CFG: SHALL issue writes in order MR (TCP 0x0001, UDP 0x0002), PORTR (PORT_BASE+n), IMR (0x001F), KPALVTR_PROTOR ({KPALVTR,8'h01}, TCP only, skipped for UDP), then CR (0x0001 OPEN).
REQ-022 CFG: each write SHALL be held stable until its op_state pulse, and the step counter SHALL advance on op_state only.
REQ-023 WAIT_OPEN: SHALL read SSR repeatedly and, on an op_state pulse, compare rd_data[7:0] with the target (TCP 0x13, UDP 0x22).
REQ-024 WAIT_OPEN: on a match, a TCP socket SHALL go to LISTEN and a UDP socket SHALL set sock_ok[n] and go to NEXT.
REQ-025 LISTEN: SHALL write CR=0x0002 and, on op_state, go to WAIT_LISTEN.
REQ-026 WAIT_LISTEN: SHALL poll SSR and, on rd_data[7:0]=0x14, set sock_ok[n] and go to NEXT.
REQ-027 SHALL reset a timeout counter to 0 on entry to each wait state, increment it every clk cycle in that state, and treat a count of OP_TIMEOUT as a timeout.
REQ-028 If a match and a timeout occur in the same cycle, the match SHALL win.
REQ-029 On timeout: if retry_cnt<MAX_RETRY, SHALL go to CLOSE; otherwise SHALL leave sock_ok[n]=0 and go to NEXT.
REQ-030 CLOSE: SHALL write CR=0x0010 and, on op_state, increment retry_cnt and return to CFG at step 0.
REQ-031 NEXT: SHALL clear retry_cnt, then go to CFG with n+1 if n<NUM_SOCKETS-1, otherwise go to DONE; NEXT SHALL last 1 cycle.
REQ-032 DONE: SHALL hold done=1 and sock_ok; when enable=0, SHALL return to IDLE and keep sock_ok until the next start.
REQ-033 SHALL clear sock_ok on each IDLE to CFG transition.
REQ-034 enable falling mid-sequence SHALL be ignored, so the sequence always runs to DONE.
REQ-035 op_state pulses arriving in IDLE, NEXT or DONE SHALL be ignored.
REQ-036 The socket index and retry_cnt SHALL be sized as clog2-width and SHALL never wrap.

Reset
REQ-037 While rst_n=0, SHALL hold state=IDLE, done=0, busy=0, sock_ok=0, all counters=0, and addr/wr_data=idle word, asynchronously.
REQ-038 Reset asserted mid-operation SHALL abort immediately, and after release SHALL wait in IDLE for enable.

Verification
REQ-039 Defaults, responder returns SSR 0x13 then 0x14 -> writes 0x200=0x0001, 0x20A=7000, 0x204=0x001F, 0x22E=0x0101, 0x202=0x0001, 0x202=0x0002; socket 1 follows with PORTR=7001; done=1, sock_ok=2'b11.
REQ-040 UDP_MASK=1, SSR 0x22 -> socket 0 writes MR=0x0002, no KPALVTR write, no LISTEN write; sock_ok[0]=1.
REQ-041 Socket 0 SSR stuck at 0x00 -> four OPEN attempts and three CR=0x0010 writes, then sock_ok[0]=0, socket 1 proceeds, done=1.
REQ-042 Bench stalls op_state for 20 cycles on each write -> addr/wr_data stable throughout, no step skipped.
REQ-043 rst_n pulsed low during WAIT_LISTEN of socket 1 -> all outputs at reset values; enable=1 restarts at socket 0.
REQ-044 Match arriving in the same cycle as timeout count=OP_TIMEOUT -> match taken, no CLOSE issued.
